// File: rtl/ariane_pkg.sv
// Core-wide types shared by the decode, issue and
// scoreboard logic.
package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned REG_ADDR_BITS = 5;

    typedef enum logic [2:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        fu_t                      fu;
        logic [7:0]               op;
        logic [REG_ADDR_BITS-1:0] rs1;
        logic [REG_ADDR_BITS-1:0] rs2;
        logic [REG_ADDR_BITS-1:0] rd;
        logic [63:0]              result;
        logic                     valid;
        logic                     use_imm;
        logic                     use_pc;
        logic                     is_compressed;
    } scoreboard_entry_t;

endpackage

// File: rtl/decoded_instr_queue_pkg.sv
// Helpers shared by the decoded instruction queue
// and its pointer/occupancy controller.
package decoded_instr_queue_pkg;

    // Up/down counter step; simultaneous inc and dec cancel.
    function automatic logic [31:0] count_next(
        input logic [31:0] cnt,
        input logic        inc,
        input logic        dec
    );
        logic [31:0] res;
        res = cnt;
        unique case ({inc, dec})
            2'b10:   res = cnt + 32'd1;
            2'b01:   res = cnt - 32'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/decoded_instr_queue_fifo_ctrl.sv
// Read/write pointers and occupancy for the decoded
// instruction queue; flush wins over push and pop.
module decoded_instr_queue_fifo_ctrl
    import decoded_instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH)-1:0]   wr_ptr_o,
    output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
    output logic [$clog2(DEPTH):0]     usage_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned UW = $clog2(DEPTH) + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [UW-1:0] usage_q, usage_d;

    // Next pointers and occupancy; pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usage_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            usage_d = UW'(count_next(32'(usage_q), push_i, pop_i));
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usage_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign usage_o  = usage_q;
    assign full_o   = (usage_q == UW'(DEPTH));
    assign empty_o  = (usage_q == '0);

endmodule

// File: rtl/decoded_instr_queue.sv
// Decode-to-issue decoupling queue with a cap on the
// number of buffered control-flow instructions.
module decoded_instr_queue
    import ariane_pkg::*;
    import decoded_instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned MAX_CTRL_FLOW = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              flush_i,
    input  scoreboard_entry_t                 instr_i,
    input  logic                              is_ctrl_flow_i,
    input  logic                              instr_valid_i,
    output logic                              instr_ready_o,
    output scoreboard_entry_t                 decoded_instr_o,
    output logic                              is_ctrl_flow_o,
    output logic                              decoded_instr_valid_o,
    input  logic                              decoded_instr_ack_i,
    output logic [$clog2(DEPTH):0]            usage_o,
    output logic [$clog2(MAX_CTRL_FLOW):0]    ctrl_flow_cnt_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned UW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = $clog2(MAX_CTRL_FLOW) + 1;

    typedef struct packed {
        scoreboard_entry_t instr;
        logic              cf;
    } slot_t;

    slot_t         mem_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [UW-1:0] usage;
    logic          full;
    logic          empty;
    logic [CW-1:0] cf_cnt_q, cf_cnt_d;
    logic          ready;
    logic          push;
    logic          pop;
    slot_t         head;

    // Ready only looks at registered state, never at inputs.
    assign ready = !full && (cf_cnt_q != CW'(MAX_CTRL_FLOW));
    assign push  = instr_valid_i && ready && !flush_i;
    assign pop   = decoded_instr_ack_i && !empty && !flush_i;
    assign head  = mem_q[rd_ptr];

    decoded_instr_queue_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) i_fifo_ctrl (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (flush_i),
        .push_i   (push),
        .pop_i    (pop),
        .wr_ptr_o (wr_ptr),
        .rd_ptr_o (rd_ptr),
        .usage_o  (usage),
        .full_o   (full),
        .empty_o  (empty)
    );

    // Write the pushed entry with its control-flow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr] <= '{instr: instr_i, cf: is_ctrl_flow_i};
        end
    end

    // Control-flow count moves by pushed cf minus popped cf.
    always_comb begin
        cf_cnt_d = cf_cnt_q;
        if (flush_i) begin
            cf_cnt_d = '0;
        end else begin
            cf_cnt_d = CW'(count_next(32'(cf_cnt_q),
                                      push && is_ctrl_flow_i,
                                      pop && head.cf));
        end
    end

    // Control-flow counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cf_cnt_q <= '0;
        end else begin
            cf_cnt_q <= cf_cnt_d;
        end
    end

    // Hide stale storage when the queue is empty.
    always_comb begin
        decoded_instr_o = '0;
        is_ctrl_flow_o  = 1'b0;
        if (!empty) begin
            decoded_instr_o = head.instr;
            is_ctrl_flow_o  = head.cf;
        end
    end

    assign instr_ready_o         = ready;
    assign decoded_instr_valid_o = !empty;
    assign usage_o               = usage;
    assign ctrl_flow_cnt_o       = cf_cnt_q;

endmodule

// File: doc/decoded_instr_queue.md
# decoded_instr_queue

Decoupling queue between the decode stage and `issue_stage`. It buffers decoded `scoreboard_entry_t` instructions together with their control-flow flag and presents the oldest one to the issue stage's `decoded_instr_valid_i`/`decoded_instr_ack_o` handshake. It also limits how many control-flow instructions may sit in the queue at once, which bounds branch-predict state, and it empties completely on a flush.

## Interface
Parameters:
- `DEPTH`, 4: entries; power of two, ≥2.
- `MAX_CTRL_FLOW`, 1: maximum buffered control-flow instructions; 1..DEPTH.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `flush_i` in 1: discard all buffered entries.
- `instr_i` in `scoreboard_entry_t`: decoded instruction from decode.
- `is_ctrl_flow_i` in 1: `instr_i` is a branch or jump.
- `instr_valid_i` in 1: `instr_i` is valid.
- `instr_ready_o` out 1: queue accepts a push this cycle.
- `decoded_instr_o` out `scoreboard_entry_t`: head entry, to issue.
- `is_ctrl_flow_o` out 1: head entry's control-flow flag.
- `decoded_instr_valid_o` out 1: head is valid.
- `decoded_instr_ack_i` in 1: issue consumed the head.
- `usage_o` out $clog2(DEPTH)+1: occupied entries.
- `ctrl_flow_cnt_o` out $clog2(MAX_CTRL_FLOW)+1: buffered control-flow entries.

## Operation
- Storage: DEPTH-entry circular buffer holding `{scoreboard_entry_t, is_ctrl_flow}`, with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. The occupancy counter and the control-flow counter are separate registers.
- `instr_ready_o = (usage != DEPTH) && (ctrl_flow_cnt != MAX_CTRL_FLOW)`.
  - It is deliberately independent of `is_ctrl_flow_i`, `instr_valid_i` and `decoded_instr_ack_i`, so there is no combinational path from inputs to ready.
  - Consequence: once the control-flow limit is reached, non-control-flow instructions also stall.
- Push occurs when `instr_valid_i && instr_ready_o && !flush_i`. The entry is written at the write pointer, and the write pointer and usage are incremented. `ctrl_flow_cnt` increments if `is_ctrl_flow_i` is set.
- Pop occurs when `decoded_instr_ack_i && decoded_instr_valid_o && !flush_i`. The read pointer is incremented and usage is decremented. `ctrl_flow_cnt` decrements if the head flag is set.
- If an ack arrives while the queue is empty, it is ignored.
- Simultaneous push and pop:
  - usage is unchanged;
  - `ctrl_flow_cnt` changes by (push_cf − pop_cf);
  - this is legal at every occupancy, but push still requires `instr_ready_o`, so a full queue does not push even when it pops.
- `decoded_instr_valid_o = (usage != 0)`.
- When the queue is empty, `decoded_instr_o` and `is_ctrl_flow_o` drive all zeros. When it is non-empty they drive the entry at the read pointer.
- Flush: pointers, usage and `ctrl_flow_cnt` go to 0 in the next cycle. Flush has priority over a same-cycle push or pop. Neither counter is updated by that push or pop, and nothing is written.
- Storage contents are not cleared on flush; the output gating hides them.

## Timing
- All state is updated on the rising edge of `clk_i`.
- Asynchronous reset to empty gives these output values:
  - `decoded_instr_valid_o` = 0
  - `decoded_instr_o` = '0
  - `is_ctrl_flow_o` = 0
  - `usage_o` = 0
  - `ctrl_flow_cnt_o` = 0
  - `instr_ready_o` = 1
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle are sustained, while not full and below the control-flow limit.
- Handshake rule: `decoded_instr_o` is stable while it is valid and not acked. The queue never drops valid except through ack or flush.
- Reset asserted mid-operation discards all entries immediately, asynchronously.

## Structure
- `scoreboard_entry_t`, `TRANS_ID_BITS` and related types come from `ariane_pkg`. No new package types are added.
- A small internal `fifo_ctrl` sub-module is natural. It holds the pointers, usage counter, full/empty logic and flush handling.
- The top level adds the entry storage, the control-flow counter, ready generation and output gating.

## Test plan
- Reset, then push 4 non-control-flow entries on consecutive cycles with PCs 0x100, 0x104, 0x108 and 0x10C, with ack held low.
  - Required: usage reaches 4 and `instr_ready_o` falls after the 4th push.
  - Required: head stays PC 0x100 until acked, after which entries drain in order.
- Streaming with valid and ack held high for 10 cycles.
  - Required: after a 1-cycle initial latency, one instruction per cycle is delivered.
  - Required: usage stays at 1 and the pointers wrap correctly past DEPTH.
- Control-flow limit with `MAX_CTRL_FLOW`=1: push a branch at PC 0x200, then present PC 0x204.
  - Required: `instr_ready_o`=0 with `ctrl_flow_cnt_o`=1.
  - After the branch is acked, the cycle after the ack shows ready=1 and 0x204 is accepted.
- Flush with 3 entries buffered, asserted together with a valid push and an ack.
  - Required: next cycle usage=0, valid=0, `decoded_instr_o`='0, and the pushed entry is discarded.
- Full queue, push and ack asserted in the same cycle.
  - Required: the pop occurs, the push is refused (ready was 0), and usage becomes DEPTH-1.
- Ack while empty, and reset asserted mid-stream with 2 entries buffered.
  - Ack while empty: no state change and no underflow.
  - Reset: outputs immediately take their reset values.
